lcd_write_sequencer: RTL and testbench

LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

---
 rtl/lcd_defs.sv | 43 ++++
 rtl/lcd_delay_counter.sv | 29 ++
 rtl/lcd_write_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_defs.sv
// Shared state encodings and default delay constants for the LCD write sequencer.
package lcd_defs;

    localparam int COUNT_WIDTH = 20;
    localparam int unsigned MAX_DELAY = (2 ** COUNT_WIDTH) - 1;

    localparam int unsigned DEF_POWERUP_WAIT  = 750000;
    localparam int unsigned DEF_SETUP_CYCLES  = 2;
    localparam int unsigned DEF_ENABLE_CYCLES = 12;
    localparam int unsigned DEF_NIBBLE_GAP    = 50;
    localparam int unsigned DEF_CMD_WAIT      = 2000;
    localparam int unsigned DEF_CLEAR_WAIT    = 82000;
    localparam int unsigned DEF_INIT_WAIT_0   = 205000;
    localparam int unsigned DEF_INIT_WAIT_1   = 5000;
    localparam int unsigned DEF_INIT_WAIT_2   = 2000;
    localparam int unsigned DEF_INIT_WAIT_3   = 2000;

    localparam logic [1:0] LAST_INIT_STEP = 2'd3;

    typedef enum logic [3:0] {
        POWERUP    = 4'd0,
        INIT_SETUP = 4'd1,
        INIT_PULSE = 4'd2,
        INIT_WAIT  = 4'd3,
        IDLE       = 4'd4,
        HI_SETUP   = 4'd5,
        HI_PULSE   = 4'd6,
        GAP        = 4'd7,
        LO_SETUP   = 4'd8,
        LO_PULSE   = 4'd9,
        CMD_DONE   = 4'd10
    } lcdState_t;

    // Three 0x3 nibbles force 8-bit mode, the final 0x2 switches to 4-bit mode.
    function automatic logic [3:0] initNibble(input logic [1:0] step);
        return (step == LAST_INIT_STEP) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic isPulse(input lcdState_t s);
        return (s == INIT_PULSE) || (s == HI_PULSE) || (s == LO_PULSE);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Shared 20-bit down-counter for every sequencer delay; zero flags the edge on
// which the count reaches 0, so a load of N keeps a state for exactly N cycles.
module lcd_delay_counter
    import lcd_defs::*;
#(
    parameter logic [COUNT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] loadValue,
    output logic                   zero
);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - COUNT_WIDTH'(1);
        end
    end

    assign zero = (count == COUNT_WIDTH'(1));

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780-style 4-bit write sequencer: power-up init, then one byte per request.
// Optional macro LCD_CLEAR_WAIT_EN: clear/home commands use the longer CLEAR_WAIT.
//
// state      | meaning
// POWERUP    | wait after reset for the panel supply to settle
// INIT_SETUP | init nibble and RS=0 on the bus, E low
// INIT_PULSE | E high for the init nibble
// INIT_WAIT  | per-step init execution wait
// IDLE       | ready for a byte
// HI_SETUP   | upper nibble and RS on the bus, E low
// HI_PULSE   | E high for the upper nibble
// GAP        | E low between nibbles, bus held
// LO_SETUP   | lower nibble on the bus, E low
// LO_PULSE   | E high for the lower nibble
// CMD_DONE   | command execution wait before the next byte
module lcd_write_sequencer
    import lcd_defs::*;
#(
    parameter int unsigned POWERUP_WAIT  = DEF_POWERUP_WAIT,
    parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int unsigned ENABLE_CYCLES = DEF_ENABLE_CYCLES,
    parameter int unsigned NIBBLE_GAP    = DEF_NIBBLE_GAP,
    parameter int unsigned CMD_WAIT      = DEF_CMD_WAIT,
    parameter int unsigned CLEAR_WAIT    = DEF_CLEAR_WAIT,
    parameter int unsigned INIT_WAIT_0   = DEF_INIT_WAIT_0,
    parameter int unsigned INIT_WAIT_1   = DEF_INIT_WAIT_1,
    parameter int unsigned INIT_WAIT_2   = DEF_INIT_WAIT_2,
    parameter int unsigned INIT_WAIT_3   = DEF_INIT_WAIT_3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic [3:0] oLCD,
    output logic       oEnable,
    output logic       oRegisterSelect,
    output logic       oReadWrite
);

    localparam logic [COUNT_WIDTH-1:0] POWERUP_LOAD = COUNT_WIDTH'(POWERUP_WAIT);
    localparam logic [COUNT_WIDTH-1:0] SETUP_LOAD   = COUNT_WIDTH'(SETUP_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] ENABLE_LOAD  = COUNT_WIDTH'(ENABLE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] GAP_LOAD     = COUNT_WIDTH'(NIBBLE_GAP);
    localparam logic [COUNT_WIDTH-1:0] CMD_LOAD     = COUNT_WIDTH'(CMD_WAIT);

    // Every delay must be non-zero and fit the shared counter.
    if (POWERUP_WAIT < 1 || POWERUP_WAIT > MAX_DELAY ||
        SETUP_CYCLES < 1 || SETUP_CYCLES > MAX_DELAY ||
        ENABLE_CYCLES < 1 || ENABLE_CYCLES > MAX_DELAY ||
        NIBBLE_GAP < 1 || NIBBLE_GAP > MAX_DELAY ||
        CMD_WAIT < 1 || CMD_WAIT > MAX_DELAY ||
        CLEAR_WAIT < 1 || CLEAR_WAIT > MAX_DELAY ||
        INIT_WAIT_0 < 1 || INIT_WAIT_0 > MAX_DELAY ||
        INIT_WAIT_1 < 1 || INIT_WAIT_1 > MAX_DELAY ||
        INIT_WAIT_2 < 1 || INIT_WAIT_2 > MAX_DELAY ||
        INIT_WAIT_3 < 1 || INIT_WAIT_3 > MAX_DELAY) begin : gBadDelay
        $error("lcd_write_sequencer: delay parameter out of range");
    end

    lcdState_t              state;
    lcdState_t              stateNext;
    logic [1:0]             initStep;
    logic [1:0]             initStepNext;
    logic [7:0]             byteReg;
    logic [7:0]             byteNext;
    logic                   rsReg;
    logic                   rsNext;
    logic                   initDoneNext;
    logic [3:0]             lcdNext;
    logic                   rsOutNext;
    logic                   cntLoad;
    logic [COUNT_WIDTH-1:0] cntLoadValue;
    logic                   cntZero;
    logic [COUNT_WIDTH-1:0] cmdLoad;

    function automatic logic [COUNT_WIDTH-1:0] initWaitLoad(input logic [1:0] step);
        case (step)
            2'd0:    return COUNT_WIDTH'(INIT_WAIT_0);
            2'd1:    return COUNT_WIDTH'(INIT_WAIT_1);
            2'd2:    return COUNT_WIDTH'(INIT_WAIT_2);
            default: return COUNT_WIDTH'(INIT_WAIT_3);
        endcase
    endfunction

`ifdef LCD_CLEAR_WAIT_EN
    localparam logic [COUNT_WIDTH-1:0] CLEAR_LOAD = COUNT_WIDTH'(CLEAR_WAIT);
    logic isClearHome;

    assign isClearHome = !rsReg && (byteReg == 8'h01 || byteReg == 8'h02);
    assign cmdLoad     = isClearHome ? CLEAR_LOAD : CMD_LOAD;
`else
    assign cmdLoad = CMD_LOAD;
`endif

    lcd_delay_counter #(
        .RESET_VALUE(POWERUP_LOAD)
    ) uDelay (
        .clock    (Clock),
        .reset    (Reset),
        .load     (cntLoad),
        .loadValue(cntLoadValue),
        .zero     (cntZero)
    );

    always_comb begin
        stateNext    = state;
        initStepNext = initStep;
        byteNext     = byteReg;
        rsNext       = rsReg;
        initDoneNext = oInitDone;
        cntLoad      = 1'b0;
        cntLoadValue = '0;
        case (state)
            POWERUP: if (cntZero) begin
                stateNext    = INIT_SETUP;
                cntLoad      = 1'b1;
                cntLoadValue = SETUP_LOAD;
            end
            INIT_SETUP: if (cntZero) begin
                stateNext    = INIT_PULSE;
                cntLoad      = 1'b1;
                cntLoadValue = ENABLE_LOAD;
            end
            INIT_PULSE: if (cntZero) begin
                stateNext    = INIT_WAIT;
                cntLoad      = 1'b1;
                cntLoadValue = initWaitLoad(initStep);
            end
            INIT_WAIT: if (cntZero) begin
                if (initStep == LAST_INIT_STEP) begin
                    stateNext    = IDLE;
                    initDoneNext = 1'b1;
                end else begin
                    stateNext    = INIT_SETUP;
                    initStepNext = initStep + 2'd1;
                    cntLoad      = 1'b1;
                    cntLoadValue = SETUP_LOAD;
                end
            end
            IDLE: if (iValid && oReady) begin
                stateNext    = HI_SETUP;
                byteNext     = iData;
                rsNext       = iRS;
                cntLoad      = 1'b1;
                cntLoadValue = SETUP_LOAD;
            end
            HI_SETUP: if (cntZero) begin
                stateNext    = HI_PULSE;
                cntLoad      = 1'b1;
                cntLoadValue = ENABLE_LOAD;
            end
            HI_PULSE: if (cntZero) begin
                stateNext    = GAP;
                cntLoad      = 1'b1;
                cntLoadValue = GAP_LOAD;
            end
            GAP: if (cntZero) begin
                stateNext    = LO_SETUP;
                cntLoad      = 1'b1;
                cntLoadValue = SETUP_LOAD;
            end
            LO_SETUP: if (cntZero) begin
                stateNext    = LO_PULSE;
                cntLoad      = 1'b1;
                cntLoadValue = ENABLE_LOAD;
            end
            LO_PULSE: if (cntZero) begin
                stateNext    = CMD_DONE;
                cntLoad      = 1'b1;
                cntLoadValue = cmdLoad;
            end
            CMD_DONE: if (cntZero) begin
                stateNext = IDLE;
            end
            default: begin
                stateNext    = POWERUP;
                cntLoad      = 1'b1;
                cntLoadValue = POWERUP_LOAD;
            end
        endcase
    end

    // The bus only moves on entry to a setup state, where E is always low.
    always_comb begin
        lcdNext   = oLCD;
        rsOutNext = oRegisterSelect;
        case (stateNext)
            INIT_SETUP: begin
                lcdNext   = initNibble(initStepNext);
                rsOutNext = 1'b0;
            end
            HI_SETUP: begin
                lcdNext   = byteNext[7:4];
                rsOutNext = rsNext;
            end
            LO_SETUP: lcdNext = byteNext[3:0];
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state           <= POWERUP;
            initStep        <= 2'd0;
            byteReg         <= 8'h00;
            rsReg           <= 1'b0;
            oLCD            <= 4'h0;
            oRegisterSelect <= 1'b0;
            oEnable         <= 1'b0;
            oReady          <= 1'b0;
            oInitDone       <= 1'b0;
        end else begin
            state           <= stateNext;
            initStep        <= initStepNext;
            byteReg         <= byteNext;
            rsReg           <= rsNext;
            oLCD            <= lcdNext;
            oRegisterSelect <= rsOutNext;
            oEnable         <= isPulse(stateNext);
            oReady          <= (stateNext == IDLE);
            oInitDone       <= initDoneNext;
        end
    end

    assign oReadWrite = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: expected E pulses and ready delays are
// queued by the stimulus and checked by a monitor sampling on the falling edge.
module tb_lcd_write_sequencer;

    localparam int POWERUP_WAIT = 20;
    localparam int SETUP        = 2;
    localparam int ENABLE       = 3;
    localparam int GAP_CYC      = 4;
    localparam int CMD_WAIT     = 6;
    localparam int CLEAR_WAIT   = 30;
    localparam int INIT_WAIT    = 10;
`ifdef LCD_CLEAR_WAIT_EN
    localparam int CLEAR_EXP = 30;
`else
    localparam int CLEAR_EXP = 6;
`endif
    localparam int DONT_CARE = -2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady, oInitDone, oEnable, oRegisterSelect, oReadWrite;
    logic [3:0] oLCD;

    lcd_write_sequencer #(
        .POWERUP_WAIT (POWERUP_WAIT),
        .SETUP_CYCLES (SETUP),
        .ENABLE_CYCLES(ENABLE),
        .NIBBLE_GAP   (GAP_CYC),
        .CMD_WAIT     (CMD_WAIT),
        .CLEAR_WAIT   (CLEAR_WAIT),
        .INIT_WAIT_0  (INIT_WAIT),
        .INIT_WAIT_1  (INIT_WAIT),
        .INIT_WAIT_2  (INIT_WAIT),
        .INIT_WAIT_3  (INIT_WAIT)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iData          (iData),
        .iRS            (iRS),
        .iValid         (iValid),
        .oReady         (oReady),
        .oInitDone      (oInitDone),
        .oLCD           (oLCD),
        .oEnable        (oEnable),
        .oRegisterSelect(oRegisterSelect),
        .oReadWrite     (oReadWrite)
    );

    always #5 Clock = ~Clock;

    // nib/rs on the bus, E-high cycles, E-low cycles before the rise, and the
    // low-period index where the bus changed (-1 none, -2 not checked).
    typedef struct {
        int nib;
        int rs;
        int hi;
        int low;
        int chg;
    } pulse_t;

    pulse_t pulseQ[$];
    int     readyQ[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic expectInit();
        pulseQ.push_back('{3, 0, ENABLE, POWERUP_WAIT + SETUP, 20});
        pulseQ.push_back('{3, 0, ENABLE, INIT_WAIT + SETUP, -1});
        pulseQ.push_back('{3, 0, ENABLE, INIT_WAIT + SETUP, -1});
        pulseQ.push_back('{2, 0, ENABLE, INIT_WAIT + SETUP, INIT_WAIT});
        readyQ.push_back(INIT_WAIT);
    endtask

    task automatic expectByte(input logic [7:0] d, input logic rs, input int postWait);
        pulseQ.push_back('{int'(d[7:4]), int'(rs), ENABLE, DONT_CARE, DONT_CARE});
        pulseQ.push_back('{int'(d[3:0]), int'(rs), ENABLE, GAP_CYC + SETUP,
                           (d[7:4] == d[3:0]) ? -1 : GAP_CYC});
        readyQ.push_back(postWait);
    endtask

    task automatic waitReady(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oReady && n < limit);
        if (!oReady) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles, ready %0d required 1", name, n, oReady);
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic rs, input int postWait);
        waitReady("send_ready", 400);
        iData  = d;
        iRS    = rs;
        iValid = 1'b1;
        expectByte(d, rs, postWait);
        @(posedge Clock);
        #1 iValid = 1'b0;
    endtask

    // Monitor: pops an expected pulse on every E fall and an expected delay on
    // every oReady rise, and checks bus stability around E on every cycle.
    logic   prevEn, prevReady, prevRs;
    logic [3:0] prevLcd;
    int     lowCnt, hiCnt, chgIdx, riseLow, riseChg, riseNib, riseRs;
    pulse_t p;

    always @(negedge Clock) begin
        if (Reset) begin
            prevEn    = 1'b0;
            prevReady = 1'b0;
            prevLcd   = 4'h0;
            prevRs    = 1'b0;
            lowCnt    = 0;
            hiCnt     = 0;
            chgIdx    = -1;
        end else begin
            check("read_write_low", int'(oReadWrite), 0);
            if (oEnable) begin
                if (!prevEn) begin
                    riseLow = lowCnt;
                    riseChg = chgIdx;
                    riseNib = int'(oLCD);
                    riseRs  = int'(oRegisterSelect);
                    hiCnt   = 0;
                end else begin
                    check("lcd_stable_e_high", int'(oLCD), int'(prevLcd));
                    check("rs_stable_e_high", int'(oRegisterSelect), int'(prevRs));
                end
                hiCnt++;
            end else begin
                if (prevEn) begin
                    check("lcd_hold_after_fall", int'(oLCD), int'(prevLcd));
                    check("rs_hold_after_fall", int'(oRegisterSelect), int'(prevRs));
                    if (pulseQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse nibble %0d rs %0d required none", riseNib, riseRs);
                    end else begin
                        p = pulseQ.pop_front();
                        check("pulse_nibble", riseNib, p.nib);
                        check("pulse_rs", riseRs, p.rs);
                        check("pulse_high_cycles", hiCnt, p.hi);
                        if (p.low != DONT_CARE) check("pulse_low_before", riseLow, p.low);
                        if (p.chg != DONT_CARE) check("bus_change_index", riseChg, p.chg);
                    end
                    lowCnt = 0;
                    chgIdx = -1;
                end else if (chgIdx == -1 && (oLCD != prevLcd || oRegisterSelect != prevRs)) begin
                    chgIdx = lowCnt;
                end
                if (oReady && !prevReady) begin
                    check("init_done_at_ready", int'(oInitDone), 1);
                    if (readyQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready after %0d cycles required none", lowCnt);
                    end else begin
                        check("ready_delay", lowCnt, readyQ.pop_front());
                    end
                end
                lowCnt++;
            end
            prevEn    = oEnable;
            prevReady = oReady;
            prevLcd   = oLCD;
            prevRs    = oRegisterSelect;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_enable", int'(oEnable), 0);
        check("reset_ready", int'(oReady), 0);
        check("reset_init_done", int'(oInitDone), 0);
        check("reset_lcd", int'(oLCD), 0);
        check("reset_rs", int'(oRegisterSelect), 0);
        check("reset_read_write", int'(oReadWrite), 0);

        expectInit();
        @(posedge Clock);
        #1 Reset = 1'b0;

        sendByte(8'h48, 1'b1, CMD_WAIT);

        // Held request while busy: only one extra byte, taken when ready returns.
        sendByte(8'h48, 1'b1, CMD_WAIT);
        iData  = 8'h55;
        iRS    = 1'b1;
        iValid = 1'b1;
        expectByte(8'h55, 1'b1, CMD_WAIT);
        waitReady("held_valid_ready", 400);
        @(posedge Clock);
        #1 iValid = 1'b0;

        sendByte(8'h01, 1'b0, CLEAR_EXP);
        sendByte(8'h38, 1'b0, CMD_WAIT);
        sendByte(8'h02, 1'b0, CLEAR_EXP);
        sendByte(8'h02, 1'b1, CMD_WAIT);

        // Reset during the upper-nibble pulse.
        sendByte(8'h38, 1'b0, CMD_WAIT);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oEnable && n < 50);
        check("reach_hi_pulse", int'(oEnable), 1);
        @(posedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("midreset_enable", int'(oEnable), 0);
        check("midreset_ready", int'(oReady), 0);
        check("midreset_init_done", int'(oInitDone), 0);
        check("midreset_lcd", int'(oLCD), 0);
        check("midreset_rs", int'(oRegisterSelect), 0);
        pulseQ.delete();
        readyQ.delete();
        expectInit();
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;

        sendByte(8'hA7, 1'b1, CMD_WAIT);

        n = 0;
        while ((pulseQ.size() != 0 || readyQ.size() != 0) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        check("pulse_queue_drained", pulseQ.size(), 0);
        check("ready_queue_drained", readyQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
